// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: load/store funct3
// encodings, the access FSM state encoding and small decode helpers.
package mem_access_unit_pkg;

  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_load_f3(input logic [2:0] f);
    return f inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic is_store_f3(input logic [2:0] f);
    return f inside {F3_SB, F3_SH, F3_SW};
  endfunction

  // funct3[1:0] carries the access size for every legal encoding.
  function automatic logic addr_aligned(input logic [2:0] f, input logic [1:0] a);
    case (f[1:0])
      2'b01:   return ~a[0];
      2'b10:   return (a == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// load_extend: picks the addressed byte/half lane of a read word and
// sign- or zero-extends it according to funct3. Purely combinational.
//   rdata  : raw word from data memory
//   addr   : byte offset within the word
//   funct3 : load type
//   ext    : extended load result
module load_extend
  import mem_access_unit_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic [REG_WIDTH-1:0] rdata,
  input  logic [1:0]           addr,
  input  logic [2:0]           funct3,
  output logic [REG_WIDTH-1:0] ext
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{addr, 3'b000} +: 8];
    lane_h = rdata[{addr[1], 4'b0000} +: 16];
    case (funct3)
      F3_LB:   ext = {{(REG_WIDTH-8){lane_b[7]}}, lane_b};
      F3_LH:   ext = {{(REG_WIDTH-16){lane_h[15]}}, lane_h};
      F3_LBU:  ext = {{(REG_WIDTH-8){1'b0}}, lane_b};
      F3_LHU:  ext = {{(REG_WIDTH-16){1'b0}}, lane_h};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer. Detects an aligned
// access from the EX/MEM register, stalls the pipeline, issues one data
// memory request held until ack, then spends one DONE cycle so the
// stalled instruction can leave EX/MEM without being reissued.
//   clk, reset              : clock, synchronous active-high reset
//   EX_MEM_*                : MEM-stage instruction fields
//   dmem_req/we/addr/wdata/be, dmem_ack/rdata : data memory handshake
//   DMEM_data_out           : registered extended load result
//   mem_stall               : pipeline freeze
//   misaligned              : one-cycle misaligned-access flag
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 EX_MEM_valid,
  input  logic                 EX_MEM_mem_read,
  input  logic                 EX_MEM_mem_write,
  input  logic [2:0]           EX_MEM_funct3,
  input  logic [REG_WIDTH-1:0] EX_MEM_alu_out,
  input  logic [REG_WIDTH-1:0] EX_MEM_dataB,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic [REG_WIDTH-1:0] dmem_addr,
  output logic [REG_WIDTH-1:0] dmem_wdata,
  output logic [3:0]           dmem_be,
  input  logic                 dmem_ack,
  input  logic [REG_WIDTH-1:0] dmem_rdata,
  output logic [REG_WIDTH-1:0] DMEM_data_out,
  output logic                 mem_stall,
  output logic                 misaligned
);

  state_t               state, state_nxt;
  logic [REG_WIDTH-1:0] addr_q, data_q;
  logic [2:0]           f3_q;
  logic                 we_q;

  logic                 rd_op, wr_op, kind_ok, aligned, access, mis_hit;
  logic [3:0]           be_st;
  logic [REG_WIDTH-1:0] ext;

  // Read wins when both read and write are set; loads-only encodings
  // (LBU/LHU) on a pure write fall out as "no access".
  always_comb begin
    rd_op   = EX_MEM_mem_read;
    wr_op   = EX_MEM_mem_write & ~EX_MEM_mem_read;
    kind_ok = rd_op ? is_load_f3(EX_MEM_funct3)
                    : (wr_op & is_store_f3(EX_MEM_funct3));
    aligned = addr_aligned(EX_MEM_funct3, EX_MEM_alu_out[1:0]);
    access  = EX_MEM_valid & kind_ok & aligned;
    mis_hit = EX_MEM_valid & kind_ok & ~aligned;
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    dmem_req  = 1'b0;
    case (state)
      ST_IDLE: if (access) begin
        mem_stall = 1'b1;
        state_nxt = ST_REQ;
      end
      ST_REQ: begin
        dmem_req  = 1'b1;
        mem_stall = 1'b1;
        if (dmem_ack) state_nxt = ST_DONE;
      end
      // Always return to IDLE: the instruction still sits in EX/MEM here.
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      f3_q          <= '0;
      we_q          <= 1'b0;
      DMEM_data_out <= '0;
      misaligned    <= 1'b0;
    end else begin
      state      <= state_nxt;
      misaligned <= (state == ST_IDLE) & mis_hit;
      if (state == ST_IDLE && access) begin
        addr_q <= EX_MEM_alu_out;
        data_q <= EX_MEM_dataB;
        f3_q   <= EX_MEM_funct3;
        we_q   <= wr_op;
      end
      if (state == ST_IDLE && mis_hit)
        DMEM_data_out <= '0;
      else if (state == ST_REQ && dmem_ack)
        DMEM_data_out <= we_q ? '0 : ext;
    end
  end

  // Store lanes: replicate the datum across the word, enable only its bytes.
  always_comb begin
    be_st      = 4'b1111;
    dmem_wdata = data_q;
    case (f3_q)
      F3_SB: begin
        be_st      = 4'b0001 << addr_q[1:0];
        dmem_wdata = {(REG_WIDTH/8){data_q[7:0]}};
      end
      F3_SH: begin
        be_st      = addr_q[1] ? 4'b1100 : 4'b0011;
        dmem_wdata = {(REG_WIDTH/16){data_q[15:0]}};
      end
      default: ;
    endcase
  end

  // Loads fetch the whole word; lane selection happens on the way back.
  assign dmem_addr = {addr_q[REG_WIDTH-1:2], 2'b00};
  assign dmem_we   = (state == ST_REQ) & we_q;
  assign dmem_be   = (state != ST_REQ) ? 4'b0000 : (we_q ? be_st : 4'b1111);

  load_extend #(.REG_WIDTH(REG_WIDTH)) u_load_extend (
    .rdata  (dmem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (f3_q),
    .ext    (ext)
  );

endmodule
